// File: rtl/key_schedule_ctrl.sv
// Sequenced AES-128 key expansion: one round key per clock through a shared
// rotWord/subWord datapath, all round keys held in storage behind a registered read port.

module ks_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  assign y = SBOX[a];
endmodule

module key_schedule_ctrl #(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [0:32*NK-1]  key,
  output logic              busy,
  output logic              keys_ready,
  output logic              done,
  input  logic [3:0]        rk_idx,
  output logic [0:127]      rk_data
);
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
  localparam logic [3:0] LAST = 4'(NR);

  state_t        state;
  logic [3:0]    rnd;
  logic [7:0]    rcon;
  logic [127:0]  cur;                 // previous round key, w0 in [127:96]
  logic [127:0]  nxt;
  logic [127:0]  rk_mem [0:NR];
  logic [31:0]   rot, sub, w4, w5, w6, w7;
  logic [7:0]    rcon_nxt;

  assign rot = {cur[23:0], cur[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sub
    ks_sbox u_sbox (.a(rot[8*g +: 8]), .y(sub[8*g +: 8]));
  end

  assign w4  = cur[127:96] ^ sub ^ {rcon, 24'h0};
  assign w5  = cur[95:64]  ^ w4;
  assign w6  = cur[63:32]  ^ w5;
  assign w7  = cur[31:0]   ^ w6;
  assign nxt = {w4, w5, w6, w7};
  assign rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      keys_ready <= 1'b0;
      done       <= 1'b0;
      rnd        <= '0;
      rcon       <= 8'h01;
      cur        <= '0;
      rk_data    <= '0;
    end else begin
      done    <= 1'b0;
      rk_data <= (rk_idx <= LAST) ? rk_mem[rk_idx] : '0;
      case (state)
        IDLE, READY: if (start) begin
          cur        <= key;
          rnd        <= 4'd1;
          rcon       <= 8'h01;
          busy       <= 1'b1;
          keys_ready <= 1'b0;
          state      <= EXPAND;
        end
        EXPAND: begin
          cur  <= nxt;
          rcon <= rcon_nxt;
          if (rnd == LAST) begin
            busy       <= 1'b0;
            keys_ready <= 1'b1;
            done       <= 1'b1;
            state      <= READY;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is never cleared; it is only meaningful once keys_ready is set.
  always_ff @(posedge clk) begin
    if (state == EXPAND) rk_mem[rnd] <= nxt;
    else if (start)      rk_mem[0]   <= key;
  end
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Scoreboard bench for key_schedule_ctrl: expectations queued by stimulus, checked by a negedge monitor
// against a FIPS-197 style word-recurrence model with an S-box derived from GF(2^8) inversion.

module tb_key_schedule_ctrl;
  logic           clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [0:127]   key = '0;
  logic           busy, keys_ready, done;
  logic [3:0]     rk_idx = '0;
  logic [0:127]   rk_data;
  int             cyc = 0, total = 0, bad = 0;

  typedef struct { int due; bit is_rd; logic [127:0] val; string nm; } exp_t;
  exp_t           sb[$];
  logic [7:0]     sbx [256];
  logic [127:0]   mrk [11];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

  key_schedule_ctrl #(.NK(4), .NR(10)) dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .busy(busy),
    .keys_ready(keys_ready), .done(done), .rk_idx(rk_idx), .rk_data(rk_data));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbx[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbx[t[31:24]], sbx[t[23:16]], sbx[t[15:8]], sbx[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push(input int due, input bit rd, input logic [127:0] v, input string nm);
    exp_t e;
    e.due = due; e.is_rd = rd; e.val = v; e.nm = nm;
    sb.push_back(e);
  endtask

  // Status word is {busy, keys_ready, done}.
  task automatic push_expansion(input int c);
    for (int j = 1; j <= 10; j++) push(c + j, 1'b0, 128'(3'b100), "busy_phase");
    push(c + 11, 1'b0, 128'(3'b011), "done_cycle");
    push(c + 12, 1'b0, 128'(3'b010), "ready_hold");
  endtask

  task automatic rdv(input int idx, input logic [127:0] v, input string nm);
    @(negedge clk);
    rk_idx = 4'(idx);
    push(cyc + 1, 1'b1, v, nm);
  endtask

  task automatic rd(input int idx);
    rdv(idx, (idx <= 10) ? mrk[idx] : 128'h0, $sformatf("rk_read[%0d]", idx));
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!keys_ready && n < 20) begin @(negedge clk); n++; end
    total++;
    if (!keys_ready) begin
      bad++;
      $display("FAIL keys_ready_timeout cyc=%0d got=0 want=1", cyc);
    end
  endtask

  task automatic expand_run(input logic [127:0] k, input bit inject);
    int c;
    @(negedge clk);
    start = 1'b1; key = k; c = cyc;
    push_expansion(c);
    model_expand(k);
    @(negedge clk);
    start = 1'b0; key = rnd128();
    for (int j = 2; j <= 9; j++) begin
      @(negedge clk);
      start  = inject ? 1'($urandom_range(0, 1)) : 1'b0;
      key    = rnd128();
      rk_idx = 4'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    wait_ready();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [127:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        act = sb[i].is_rd ? 128'(rk_data) : 128'({busy, keys_ready, done});
        total++;
        if (act !== sb[i].val) begin
          bad++;
          $display("FAIL %s cyc=%0d got=%h want=%h", sb[i].nm, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    int c0;
    build_sbox();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    push(cyc + 1, 1'b0, 128'h0, "reset_status");
    push(cyc + 1, 1'b1, 128'h0, "reset_rk_data");
    @(negedge clk);
    reset = 1'b0;
    push(cyc + 1, 1'b0, 128'h0, "idle_status");
    push(cyc + 2, 1'b0, 128'h0, "idle_status");
    repeat (2) @(negedge clk);

    // FIPS-197 vector, then full read sweep including out-of-range indices
    expand_run(FIPS_KEY, 1'b0);
    rdv(1, FIPS_RK1, "fips_rk1");
    rdv(10, FIPS_RK10, "fips_rk10");
    rdv(0, FIPS_KEY, "fips_rk0");
    for (int i = 0; i < 16; i++) rd(i);

    // Re-key with stray starts during expansion
    expand_run(FIPS_KEY, 1'b1);
    rdv(10, FIPS_RK10, "ignored_start_rk10");
    repeat (3) begin
      expand_run(rnd128(), 1'b1);
      repeat (8) rd($urandom_range(0, 15));
    end

    // Reset during the 5th expansion cycle
    @(negedge clk);
    start = 1'b1; key = rnd128();
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    push(cyc + 1, 1'b0, 128'h0, "reset_mid_status");
    push(cyc + 1, 1'b1, 128'h0, "reset_mid_rk_data");
    @(negedge clk);
    reset = 1'b0;
    for (int j = 1; j <= 14; j++) push(cyc + j, 1'b0, 128'h0, "after_abort");
    repeat (14) @(negedge clk);
    expand_run(FIPS_KEY, 1'b0);
    rdv(1, FIPS_RK1, "restart_rk1");
    rdv(10, FIPS_RK10, "restart_rk10");

    // All-zero key re-key from READY
    expand_run(128'h0, 1'b0);
    rdv(10, ZERO_RK10, "zero_rk10");
    rd(0); rd(5); rd(11);

    // start held high: back-to-back expansions, one done per 11 cycles
    @(negedge clk);
    start = 1'b1; key = rnd128(); c0 = cyc;
    model_expand(key);
    for (int b = 0; b < 3; b++) begin
      for (int j = 1; j <= 10; j++) push(c0 + 11*b + j, 1'b0, 128'(3'b100), "held_busy");
      push(c0 + 11*b + 11, 1'b0, 128'(3'b011), "held_done");
    end
    push(c0 + 34, 1'b0, 128'(3'b010), "held_ready");
    repeat (23) @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 11; i++) rd(i);
    rd(15);

    repeat (3) @(negedge clk);
    foreach (sb[i]) begin
      total++; bad++;
      $display("FAIL unchecked_%s due=%0d", sb[i].nm, sb[i].due);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
